// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned shift-and-add multiplier controller driving one external
// DATA_WIDTH-bit adder; one product every DATA_WIDTH+2 cycles with a free-running sink.
module shift_add_mult_ctrl #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   op_a,
  input  logic [DATA_WIDTH-1:0]   op_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] product,
  output logic [DATA_WIDTH-1:0]   add_a,
  output logic [DATA_WIDTH-1:0]   add_b,
  input  logic [DATA_WIDTH-1:0]   add_sum,
  input  logic                    add_co
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*DATA_WIDTH-1:0] p_q, p_d;
  logic [CntW-1:0]         cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      mcand_q <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    product   = '0;
    add_a     = '0;
    add_b     = '0;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mcand_d = op_a;
          p_d     = {{DATA_WIDTH{1'b0}}, op_b};
          cnt_d   = '0;
          state_d = StRun;
        end
      end

      StRun: begin
        // A zero multiplier bit adds exactly 0, so one update rule covers both cases.
        add_a   = p_q[2*DATA_WIDTH-1:DATA_WIDTH];
        add_b   = p_q[0] ? mcand_q : '0;
        p_d     = {add_co, add_sum, p_q[DATA_WIDTH-1:1]};
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(DATA_WIDTH - 1)) begin
          state_d = StDone;
        end
      end

      StDone: begin
        out_valid = 1'b1;
        product   = p_q;
        if (out_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Self-checking bench: table-driven W=8 vectors, reset-abort sequence and a
// randomized W=32 back-to-back stream scored against plain a*b arithmetic.
module tb_shift_add_mult_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // W = 8 instance
  logic        in_valid8, in_ready8, out_valid8, out_ready8, add_co8;
  logic [7:0]  op_a8, op_b8, add_a8, add_b8, add_sum8;
  logic [15:0] product8;
  assign {add_co8, add_sum8} = 9'(add_a8) + 9'(add_b8);

  shift_add_mult_ctrl #(.DATA_WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .op_a      (op_a8),
    .op_b      (op_b8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .product   (product8),
    .add_a     (add_a8),
    .add_b     (add_b8),
    .add_sum   (add_sum8),
    .add_co    (add_co8)
  );

  // W = 32 instance
  logic        in_valid32, in_ready32, out_valid32, out_ready32, add_co32;
  logic [31:0] op_a32, op_b32, add_a32, add_b32, add_sum32;
  logic [63:0] product32;
  assign {add_co32, add_sum32} = 33'(add_a32) + 33'(add_b32);

  shift_add_mult_ctrl #(.DATA_WIDTH(32)) u_dut32 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid32),
    .in_ready  (in_ready32),
    .op_a      (op_a32),
    .op_b      (op_b32),
    .out_valid (out_valid32),
    .out_ready (out_ready32),
    .product   (product32),
    .add_a     (add_a32),
    .add_b     (add_b32),
    .add_sum   (add_sum32),
    .add_co    (add_co32)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    int          stall;
    logic [15:0] req;
    bit          want_co;
  } vec_t;

  // One full W=8 transaction; in_valid is held high with junk operands while busy.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input int stall,
                      input logic [15:0] req, input bit want_co);
    int k;
    bit seen, saw_co, bad_run, bad_addb, bad_hold;
    seen = 0; saw_co = 0; bad_run = 0; bad_addb = 0; bad_hold = 0;
    check("idle_in_ready", 64'(in_ready8), 64'(1));
    in_valid8  = 1'b1;
    op_a8      = a;
    op_b8      = b;
    out_ready8 = 1'b0;
    @(negedge clk);
    op_a8 = 8'($urandom);
    op_b8 = 8'($urandom);
    k = 0;
    while (k < 40 && !seen) begin
      if (out_valid8) begin
        seen = 1;
      end else begin
        if (in_ready8 || product8 != 16'd0) bad_run = 1;
        if (add_co8) saw_co = 1;
        if (add_b8 != 8'd0 && add_b8 != a) bad_addb = 1;
        @(negedge clk);
        k++;
      end
    end
    check("latency", 64'(k), 64'(8));
    check("product", 64'(product8), 64'(req));
    check("run_outputs", 64'(bad_run), 64'(0));
    check("add_b_value", 64'(bad_addb), 64'(0));
    if (want_co) check("carry_seen", 64'(saw_co), 64'(1));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      if (!out_valid8 || product8 != req || in_ready8) bad_hold = 1;
    end
    if (stall > 0) check("backpressure_hold", 64'(bad_hold), 64'(0));
    out_ready8 = 1'b1;
    @(negedge clk);
    in_valid8  = 1'b0;
    out_ready8 = 1'b0;
    check("post_handshake", 64'({in_ready8, out_valid8, product8}), 64'({1'b1, 1'b0, 16'd0}));
  endtask

  vec_t vecs[10];
  logic [63:0] expq[$];

  initial begin
    int last_acc, n_out;
    bit bad_abort;
    logic [63:0] exp_p;

    rst = 1'b1;
    in_valid8 = 1'b0; out_ready8 = 1'b0; op_a8 = '0; op_b8 = '0;
    in_valid32 = 1'b0; out_ready32 = 1'b0; op_a32 = '0; op_b32 = '0;

    vecs[0] = '{a: 8'd3,   b: 8'd5,   stall: 0, req: 16'd15,    want_co: 1'b0};
    vecs[1] = '{a: 8'd255, b: 8'd255, stall: 0, req: 16'd65025, want_co: 1'b1};
    vecs[2] = '{a: 8'd0,   b: 8'd200, stall: 0, req: 16'd0,     want_co: 1'b0};
    vecs[3] = '{a: 8'd200, b: 8'd0,   stall: 0, req: 16'd0,     want_co: 1'b0};
    vecs[4] = '{a: 8'd13,  b: 8'd11,  stall: 5, req: 16'd143,   want_co: 1'b0};
    vecs[5] = '{a: 8'd1,   b: 8'd255, stall: 0, req: 16'd255,   want_co: 1'b0};
    vecs[6] = '{a: 8'd128, b: 8'd2,   stall: 2, req: 16'd256,   want_co: 1'b0};
    for (int i = 7; i < 10; i++) begin
      vecs[i].a       = 8'($urandom);
      vecs[i].b       = 8'($urandom);
      vecs[i].stall   = int'($urandom_range(0, 3));
      vecs[i].req     = 16'(vecs[i].a) * 16'(vecs[i].b);
      vecs[i].want_co = 1'b0;
    end

    repeat (2) @(negedge clk);
    check("reset_outputs8", 64'({in_ready8, out_valid8, product8, add_a8, add_b8}),
          64'({1'b1, 1'b0, 16'd0, 8'd0, 8'd0}));
    check("reset_outputs32", 64'({in_ready32, out_valid32}), 64'({1'b1, 1'b0}));
    check("reset_product32", product32, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].stall, vecs[i].req, vecs[i].want_co);
    end

    // Abort 200*100 at RUN cycle 4, then a clean 7*9.
    in_valid8 = 1'b1; op_a8 = 8'd200; op_b8 = 8'd100; out_ready8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_run_busy", 64'(in_ready8), 64'(0));
    rst = 1'b1;
    #1;
    check("abort_reset_outputs", 64'({in_ready8, out_valid8, product8, add_a8, add_b8}),
          64'({1'b1, 1'b0, 16'd0, 8'd0, 8'd0}));
    @(negedge clk);
    check("abort_reset_held", 64'({in_ready8, out_valid8, product8, add_a8, add_b8}),
          64'({1'b1, 1'b0, 16'd0, 8'd0, 8'd0}));
    rst = 1'b0;
    bad_abort = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid8 || !in_ready8) bad_abort = 1;
    end
    check("no_output_after_abort", 64'(bad_abort), 64'(0));
    out_ready8 = 1'b0;
    run8(8'd7, 8'd9, 0, 16'd63, 1'b0);

    // W=32 back-to-back stream, in_valid held high, sink always ready.
    in_valid32 = 1'b1; out_ready32 = 1'b1;
    last_acc = -1; n_out = 0;
    for (int c = 0; c < 34 * 10 + 4; c++) begin
      if (out_valid32) begin
        n_out++;
        if (expq.size() == 0) begin
          check("w32_spurious_output", 64'(1), 64'(0));
        end else begin
          exp_p = expq.pop_front();
          check("w32_product", product32, exp_p);
        end
      end
      op_a32 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      op_b32 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      if (in_ready32) begin
        if (last_acc >= 0) check("w32_accept_spacing", 64'(c - last_acc), 64'(34));
        last_acc = c;
        expq.push_back(64'(op_a32) * 64'(op_b32));
      end
      @(negedge clk);
    end
    in_valid32 = 1'b0;
    check("w32_output_count_ok", 64'(n_out >= 9), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
